// File: rtl/tt_um_seq_divider_if.sv
// Tiny Tapeout pin bundle for the sequential divider.
// The master side drives the inputs and the slave side drives the outputs.
interface tt_um_seq_divider_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_seq_divider.sv
// 4-bit unsigned restoring divider producing one quotient bit per clock.
// Optional macro SEQ_DIV_EARLY_EXIT_EN finishes at once when the divisor exceeds the dividend.
module tt_um_seq_divider #(
  parameter bit SYNC_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  tt_um_seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state_q, state_d;
  logic       s_sync_q, s_sync_d;
  logic       s_prev_q, s_prev_d;
  logic [3:0] n_q, n_d;
  logic [3:0] d_q, d_d;
  logic [3:0] pr_q, pr_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] q_acc_q, q_acc_d;
  logic [3:0] quo_q, quo_d;
  logic [3:0] rem_q, rem_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       dbz_q, dbz_d;

  logic       s_cur;
  logic       start_evt;
  logic       early_exit;
  logic [4:0] pr_shift;
  logic [4:0] trial;
  logic [4:0] pr_next;
  logic       unused_ok;

  assign s_cur     = SYNC_START ? s_sync_q : bus.uio_in[0];
  assign start_evt = s_cur & ~s_prev_q;
  assign unused_ok = &{1'b0, ena, bus.uio_in[7:1]};

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early_exit = (bus.ui_in[7:4] > bus.ui_in[3:0]);
`else
  assign early_exit = 1'b0;
`endif

  // A restored remainder is always below D, so only 4 bits are kept; the
  // fifth bit exists only in the shifted/trial values.
  assign pr_shift = {pr_q, n_q[cnt_q]};
  assign trial    = pr_shift - {1'b0, d_q};
  assign pr_next  = trial[4] ? pr_shift : trial;

  always_comb begin
    state_d  = state_q;
    s_sync_d = bus.uio_in[0];
    s_prev_d = s_cur;
    n_d      = n_q;
    d_d      = d_q;
    pr_d     = pr_q;
    cnt_d    = cnt_q;
    q_acc_d  = q_acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = done_q;
    dbz_d    = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_evt) begin
          n_d    = bus.ui_in[3:0];
          d_d    = bus.ui_in[7:4];
          done_d = 1'b0;
          dbz_d  = 1'b0;
          if (bus.ui_in[7:4] == 4'd0) begin
            state_d = DONE;
            quo_d   = 4'hF;
            rem_d   = bus.ui_in[3:0];
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else if (early_exit) begin
            state_d = DONE;
            quo_d   = 4'h0;
            rem_d   = bus.ui_in[3:0];
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            pr_d    = 4'd0;
            cnt_d   = 2'd3;
            q_acc_d = 4'd0;
          end
        end
      end
      RUN: begin
        pr_d           = pr_next[3:0];
        q_acc_d[cnt_q] = ~trial[4];
        cnt_d          = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          quo_d   = q_acc_d;
          rem_d   = pr_next[3:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_sync_q <= 1'b0;
      s_prev_q <= 1'b0;
      n_q      <= 4'd0;
      d_q      <= 4'd0;
      pr_q     <= 4'd0;
      cnt_q    <= 2'd0;
      q_acc_q  <= 4'd0;
      quo_q    <= 4'd0;
      rem_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_sync_q <= s_sync_d;
      s_prev_q <= s_prev_d;
      n_q      <= n_d;
      d_q      <= d_d;
      pr_q     <= pr_d;
      cnt_q    <= cnt_d;
      q_acc_q  <= q_acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.uo_out  = {rem_q, quo_q};
  assign bus.uio_out = {4'b0000, dbz_q, done_q, busy_q, 1'b0};
  assign bus.uio_oe  = 8'b0000_1110;

endmodule
